// File: rtl/dsp_rf_pkg.sv
// Shared register-file constants, address type and write-back requester indices.
package dsp_rf_pkg;

  localparam int unsigned RF_AW   = 4;
  localparam int unsigned RF_DW   = 32;
  localparam int unsigned RF_NREG = 16;

  typedef logic [RF_AW-1:0] rf_addr_t;

  localparam rf_addr_t RF_ZERO = '0;

  // Write-back requester slots on the arbiter
  localparam int unsigned WB_ALU  = 0;
  localparam int unsigned WB_MAC  = 1;
  localparam int unsigned WB_LD   = 2;
  localparam int unsigned WB_NREQ = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && req[IW'(idx)]) begin
        found            = 1'b1;
        gnt[IW'(idx)]    = 1'b1;
        gnt_idx          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant, registered write stage,
// and a pending-write scoreboard for RAW hazard checks.
module rf_wb_arbiter
  import dsp_rf_pkg::*;
#(
  parameter int unsigned NREQ = WB_NREQ,
  parameter int unsigned AW   = RF_AW,
  parameter int unsigned DW   = RF_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rw,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_rw,
  output logic [DW-1:0]      rf_wdata,
  input  logic               sb_set,
  input  logic [AW-1:0]      sb_rd,
  input  logic [AW-1:0]      chk_ra,
  input  logic [AW-1:0]      chk_rb,
  output logic               busy_a,
  output logic               busy_b
);

  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG = 1 << AW;

  logic [IW-1:0]   last_q;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] req_gated;
  logic            rst_d_q;
  logic            block_c;
  logic            xfer;
  logic            wr_en;
  logic [AW-1:0]   sel_rw;
  logic [DW-1:0]   sel_wdata;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_n;

  // No grants during reset or the cycle after it; pending requests are re-presented.
  assign block_c   = rst | rst_d_q;
  assign req_gated = block_c ? '0 : req_valid;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req_gated),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  // One-hot AND-OR select of the granted requester's payload
  always_comb begin
    sel_rw    = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_rw    = req_rw[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Writes to r0 are consumed but never reach the file or the scoreboard
  assign wr_en = xfer && (sel_rw != AW'(RF_ZERO));

  // Clear on write-back, then set from issue so a same-register set wins
  always_comb begin
    busy_n = busy_q;
    if (wr_en) begin
      busy_n[sel_rw] = 1'b0;
    end
    if (sb_set && (sb_rd != AW'(RF_ZERO))) begin
      busy_n[sb_rd] = 1'b1;
    end
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_d_q  <= 1'b1;
      last_q   <= IW'(NREQ - 1);
      rf_we    <= 1'b0;
      rf_rw    <= '0;
      rf_wdata <= '0;
      busy_q   <= '0;
    end else begin
      rst_d_q <= 1'b0;
      if (xfer) begin
        last_q <= gnt_idx;
      end
      rf_we <= wr_en;
      if (wr_en) begin
        rf_rw    <= sel_rw;
        rf_wdata <= sel_wdata;
      end
      busy_q <= busy_n;
    end
  end

  assign busy_a = busy_q[chk_ra];
  assign busy_b = busy_q[chk_rb];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, then random
// traffic against a behavioural model of grant order, write stage and scoreboard.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [11:0] req_rw;
  logic [95:0] req_wdata;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [3:0]  rf_rw;
  logic [31:0] rf_wdata;
  logic        sb_set;
  logic [3:0]  sb_rd;
  logic [3:0]  chk_ra;
  logic [3:0]  chk_rb;
  logic        busy_a;
  logic        busy_b;

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_rw     (rf_rw),
    .rf_wdata  (rf_wdata),
    .sb_set    (sb_set),
    .sb_rd     (sb_rd),
    .chk_ra    (chk_ra),
    .chk_rb    (chk_rb),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        r;
    bit [2:0]  v;
    bit [11:0] rw;
    bit [95:0] wd;
    bit        s;
    bit [3:0]  sd;
    bit [3:0]  ra;
    bit [3:0]  rb;
    bit [2:0]  er;
    bit        eba;
    bit        ebb;
    bit        ewe;
    bit [3:0]  erw;
    bit [31:0] ewd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int        m_last     = 2;
  bit [15:0] m_busy     = '0;
  bit        m_we       = 1'b0;
  bit [3:0]  m_rw       = '0;
  bit [31:0] m_wd       = '0;
  bit        m_rst_prev = 1'b1;

  vec_t tab[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int model_grant(input bit [2:0] v);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic vec_t mk(bit r, bit [2:0] v, bit [11:0] rw, bit [95:0] wd, bit s, bit [3:0] sd,
                              bit [3:0] ra, bit [3:0] rb, bit [2:0] er, bit eba, bit ebb,
                              bit ewe, bit [3:0] erw, bit [31:0] ewd);
    vec_t t;
    t.r = r; t.v = v; t.rw = rw; t.wd = wd; t.s = s; t.sd = sd; t.ra = ra; t.rb = rb;
    t.er = er; t.eba = eba; t.ebb = ebb; t.ewe = ewe; t.erw = erw; t.ewd = ewd;
    return t;
  endfunction

  task automatic run_cycle(input vec_t s, input bit use_tab, output int g);
    bit        blk;
    bit [2:0]  er;
    bit        eba, ebb, ewe;
    bit [3:0]  erw, rw_g;
    bit [31:0] ewd;
    rst       = s.r;
    req_valid = s.v;
    req_rw    = s.rw;
    req_wdata = s.wd;
    sb_set    = s.s;
    sb_rd     = s.sd;
    chk_ra    = s.ra;
    chk_rb    = s.rb;
    blk = s.r || m_rst_prev;
    g   = blk ? -1 : model_grant(s.v);
    er  = (g < 0) ? 3'b000 : 3'(1 << g);
    eba = (s.ra != 0) && m_busy[s.ra];
    ebb = (s.rb != 0) && m_busy[s.rb];
    if (use_tab) begin
      er = s.er; eba = s.eba; ebb = s.ebb;
    end
    #2;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy_a", 32'(busy_a), 32'(eba));
    chk("busy_b", 32'(busy_b), 32'(ebb));
    @(posedge clk);
    if (s.r) begin
      m_last = 2; m_busy = '0; m_we = 1'b0; m_rw = '0; m_wd = '0;
    end else begin
      m_we = 1'b0;
      if (g >= 0) begin
        m_last = g;
        rw_g   = s.rw[g*4 +: 4];
        if (rw_g != 0) begin
          m_we = 1'b1;
          m_rw = rw_g;
          m_wd = s.wd[g*32 +: 32];
          m_busy[rw_g] = 1'b0;
        end
      end
      if (s.s && s.sd != 0) m_busy[s.sd] = 1'b1;
    end
    m_rst_prev = s.r;
    ewe = use_tab ? s.ewe : m_we;
    erw = use_tab ? s.erw : m_rw;
    ewd = use_tab ? s.ewd : m_wd;
    #1;
    chk("rf_we", 32'(rf_we), 32'(ewe));
    chk("rf_rw", 32'(rf_rw), 32'(erw));
    chk("rf_wdata", rf_wdata, ewd);
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit [95:0] wd3;
    bit [2:0]  pend;
    bit [3:0]  prw [3];
    bit [31:0] pwd [3];
    int        g;
    wd3 = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};

    //        r  v       rw       wd                                   s  sd ra rb  er      ba bb we rw  wd
    tab.push_back(mk(1, 3'b000, 12'h000, '0,                           0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(1, 3'b111, 12'h321, wd3,                          0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 3'b001, 12'h005, {64'h0, 32'hDEADBEEF},        0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 3'b001, 12'h005, {64'h0, 32'hDEADBEEF},        0, 0, 0, 0, 3'b001, 0, 0, 1, 5, 32'hDEADBEEF));
    tab.push_back(mk(0, 3'b000, 12'h000, '0,                           0, 0, 0, 0, 3'b000, 0, 0, 0, 5, 32'hDEADBEEF));
    tab.push_back(mk(1, 3'b000, 12'h000, '0,                           0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 0, 0, 3'b001, 0, 0, 1, 1, 32'hA0));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 0, 0, 3'b010, 0, 0, 1, 2, 32'hA1));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 0, 0, 3'b100, 0, 0, 1, 3, 32'hA2));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 0, 0, 3'b001, 0, 0, 1, 1, 32'hA0));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 0, 0, 3'b010, 0, 0, 1, 2, 32'hA1));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 0, 0, 3'b100, 0, 0, 1, 3, 32'hA2));
    tab.push_back(mk(0, 3'b000, 12'h000, '0,                           1, 7, 7, 0, 3'b000, 0, 0, 0, 3, 32'hA2));
    tab.push_back(mk(0, 3'b010, 12'h070, {32'h0, 32'hB7, 32'h0},       0, 0, 7, 0, 3'b010, 1, 0, 1, 7, 32'hB7));
    tab.push_back(mk(0, 3'b000, 12'h000, '0,                           0, 0, 7, 0, 3'b000, 0, 0, 0, 7, 32'hB7));
    tab.push_back(mk(0, 3'b001, 12'h004, {64'h0, 32'hC4},              1, 4, 4, 0, 3'b001, 0, 0, 1, 4, 32'hC4));
    tab.push_back(mk(0, 3'b000, 12'h000, '0,                           1, 0, 4, 0, 3'b000, 1, 0, 0, 4, 32'hC4));
    tab.push_back(mk(0, 3'b000, 12'h000, '0,                           0, 0, 0, 4, 3'b000, 0, 1, 0, 4, 32'hC4));
    tab.push_back(mk(0, 3'b010, 12'h090, {32'h0, 32'hD9, 32'h0},       0, 0, 0, 0, 3'b010, 0, 0, 1, 9, 32'hD9));
    tab.push_back(mk(0, 3'b101, 12'h006, {32'hF0, 32'h0, 32'hE6},      0, 0, 0, 0, 3'b100, 0, 0, 0, 9, 32'hD9));
    tab.push_back(mk(0, 3'b001, 12'h006, {64'h0, 32'hE6},              0, 0, 0, 0, 3'b001, 0, 0, 1, 6, 32'hE6));
    tab.push_back(mk(0, 3'b000, 12'h000, '0,                           1, 5, 0, 0, 3'b000, 0, 0, 0, 6, 32'hE6));
    tab.push_back(mk(0, 3'b000, 12'h000, '0,                           1, 6, 0, 0, 3'b000, 0, 0, 0, 6, 32'hE6));
    tab.push_back(mk(0, 3'b000, 12'h000, '0,                           1, 7, 0, 4, 3'b000, 0, 1, 0, 6, 32'hE6));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 5, 7, 3'b010, 1, 1, 1, 2, 32'hA1));
    tab.push_back(mk(1, 3'b111, 12'h321, wd3,                          0, 0, 6, 4, 3'b000, 1, 1, 0, 0, 32'h0));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 6, 4, 3'b000, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 3'b111, 12'h321, wd3,                          0, 0, 5, 7, 3'b001, 0, 0, 1, 1, 32'hA0));
    tab.push_back(mk(0, 3'b000, 12'h000, '0,                           0, 0, 5, 7, 3'b000, 0, 0, 0, 1, 32'hA0));

    #1;
    foreach (tab[i]) run_cycle(tab[i], 1'b1, g);

    // Random traffic: requesters hold their payload until granted
    pend = '0;
    for (int i = 0; i < 3; i++) begin
      prw[i] = '0;
      pwd[i] = '0;
    end
    for (int n = 0; n < 1500; n++) begin
      vec_t s;
      s = mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          prw[i]  = 4'($urandom_range(0, 15));
          pwd[i]  = $urandom;
        end
        s.v[i]          = pend[i];
        s.rw[i*4 +: 4]  = prw[i];
        s.wd[i*32 +: 32] = pwd[i];
      end
      s.r  = ($urandom_range(0, 63) == 0);
      s.s  = ($urandom_range(0, 2) == 0);
      s.sd = 4'($urandom_range(0, 15));
      s.ra = 4'($urandom_range(0, 15));
      s.rb = 4'($urandom_range(0, 15));
      run_cycle(s, 1'b0, g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
